// File: rtl/updown_counter_gen.sv
// Up/down counter with an enable-gated tick prescaler, synchronous load,
// programmable terminal value and wrap/saturate behaviour at the boundaries.
module updown_counter_gen #(
    parameter int              WIDTH    = 4,
    parameter int              TICK_DIV = 100000000,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ctrl,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             wrap,
    output logic             at_max,
    output logic             at_min
);

    localparam int              PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PS_LAST = PW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    // Value taken when a step runs off the top / bottom of the range.
    localparam logic [WIDTH-1:0] UP_EDGE_VAL = SATURATE ? MAX_C : ZERO_C;
    localparam logic [WIDTH-1:0] DN_EDGE_VAL = SATURATE ? ZERO_C : MAX_C;

    logic [WIDTH-1:0] r_count;
    logic [PW-1:0]    r_presc;
    logic             r_tick;
    logic             r_wrap;

    logic             w_step;
    logic             w_at_max;
    logic             w_at_min;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_at_max       = (r_count == MAX_C);
    assign w_at_min       = (r_count == ZERO_C);
    assign w_step         = en && (r_presc == PS_LAST);
    assign w_load_clamped = (load_val > MAX_C) ? MAX_C : load_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= ZERO_C;
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (load) begin
            // A step coinciding with a load is dropped and the phase restarts.
            r_count <= w_load_clamped;
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_tick <= w_step;
            r_wrap <= 1'b0;
            if (w_step) begin
                r_presc <= '0;
                if (ctrl) begin
                    if (w_at_max) begin
                        r_count <= UP_EDGE_VAL;
                        r_wrap  <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end else begin
                    if (w_at_min) begin
                        r_count <= DN_EDGE_VAL;
                        r_wrap  <= 1'b1;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
            end else if (en) begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    assign count  = r_count;
    assign tick   = r_tick;
    assign wrap   = r_wrap;
    assign at_max = w_at_max;
    assign at_min = w_at_min;

endmodule

// File: tb/tb_updown_counter_gen.sv
// Directed bench: wrap-mode and saturate-mode counters (TICK_DIV=4, MAX_VAL=9)
// plus an 8-bit TICK_DIV=1 counter, all sharing the control inputs.
module tb_updown_counter_gen;

    logic       clk = 1'b0;
    logic       rst, en, ctrl, load;
    logic [3:0] load_val;
    logic [7:0] c_load_val;

    logic [3:0] a_count, b_count;
    logic [7:0] c_count;
    logic       a_tick, a_wrap, a_max, a_min;
    logic       b_tick, b_wrap, b_max, b_min;
    logic       c_tick, c_wrap, c_max, c_min;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    updown_counter_gen #(.WIDTH(4), .TICK_DIV(4), .MAX_VAL(9), .SATURATE(1'b0)) u_a (
        .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .load(load), .load_val(load_val),
        .count(a_count), .tick(a_tick), .wrap(a_wrap), .at_max(a_max), .at_min(a_min)
    );

    updown_counter_gen #(.WIDTH(4), .TICK_DIV(4), .MAX_VAL(9), .SATURATE(1'b1)) u_b (
        .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .load(load), .load_val(load_val),
        .count(b_count), .tick(b_tick), .wrap(b_wrap), .at_max(b_max), .at_min(b_min)
    );

    updown_counter_gen #(.WIDTH(8), .TICK_DIV(1), .MAX_VAL(255), .SATURATE(1'b0)) u_c (
        .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .load(load), .load_val(c_load_val),
        .count(c_count), .tick(c_tick), .wrap(c_wrap), .at_max(c_max), .at_min(c_min)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       ctrl;
        logic       load;
        logic [3:0] load_val;
        logic [3:0] e_count;
        logic       e_tick;
        logic       e_wrap;
        logic       e_max;
        logic       e_min;
    } vec_t;

    vec_t vecs [45];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ticks;
        int wraps;

        rst = 1'b1; en = 1'b0; ctrl = 1'b1; load = 1'b0;
        load_val = 4'd0; c_load_val = 8'd0;

        // Reset vector followed by 44 enabled up-count cycles.
        vecs[0].rst = 1'b1; vecs[0].en = 1'b0; vecs[0].ctrl = 1'b1;
        vecs[0].load = 1'b0; vecs[0].load_val = 4'd0;
        vecs[0].e_count = 4'd0; vecs[0].e_tick = 1'b0; vecs[0].e_wrap = 1'b0;
        vecs[0].e_max = 1'b0; vecs[0].e_min = 1'b1;
        for (int k = 1; k <= 44; k++) begin
            int v;
            v = (k / 4) % 10;
            vecs[k].rst = 1'b0; vecs[k].en = 1'b1; vecs[k].ctrl = 1'b1;
            vecs[k].load = 1'b0; vecs[k].load_val = 4'd0;
            vecs[k].e_count = 4'(v);
            vecs[k].e_tick  = (k % 4 == 0);
            vecs[k].e_wrap  = (k == 40);
            vecs[k].e_max   = (v == 9);
            vecs[k].e_min   = (v == 0);
        end

        ticks = 0;
        wraps = 0;
        for (int i = 0; i < 45; i++) begin
            rst = vecs[i].rst; en = vecs[i].en; ctrl = vecs[i].ctrl;
            load = vecs[i].load; load_val = vecs[i].load_val;
            cyc();
            $display("vec %0d: count=%0d tick=%0d wrap=%0d", i, a_count, a_tick, a_wrap);
            chk("vec_count", 32'(a_count), 32'(vecs[i].e_count));
            chk("vec_tick",  32'(a_tick),  32'(vecs[i].e_tick));
            chk("vec_wrap",  32'(a_wrap),  32'(vecs[i].e_wrap));
            chk("vec_at_max", 32'(a_max),  32'(vecs[i].e_max));
            chk("vec_at_min", 32'(a_min),  32'(vecs[i].e_min));
            if (i > 0) begin
                ticks += int'(a_tick);
                wraps += int'(a_wrap);
            end
        end
        chk("up_tick_total", 32'(ticks), 32'd11);
        chk("up_wrap_total", 32'(wraps), 32'd1);

        // Down from 0 wraps to 9; ctrl noise between steps must be ignored.
        load = 1'b1; load_val = 4'd0; en = 1'b1; ctrl = 1'b0;
        cyc();
        $display("seq down: load 0 count=%0d", a_count);
        chk("dn_load_count", 32'(a_count), 32'd0);
        load = 1'b0; ctrl = 1'b1;
        cyc(); cyc();
        ctrl = 1'b0;
        cyc();
        chk("dn_pre_tick", 32'(a_tick), 32'd0);
        cyc();
        $display("seq down: step1 count=%0d wrap=%0d", a_count, a_wrap);
        chk("dn_wrap_count", 32'(a_count), 32'd9);
        chk("dn_wrap_flag",  32'(a_wrap),  32'd1);
        chk("dn_wrap_tick",  32'(a_tick),  32'd1);
        repeat (3) cyc();
        chk("dn_mid_wrap", 32'(a_wrap), 32'd0);
        cyc();
        $display("seq down: step2 count=%0d wrap=%0d", a_count, a_wrap);
        chk("dn_8_count", 32'(a_count), 32'd8);
        chk("dn_8_wrap",  32'(a_wrap),  32'd0);
        chk("dn_8_tick",  32'(a_tick),  32'd1);

        // Saturate mode holds at 9 but still ticks and flags wrap.
        load = 1'b1; load_val = 4'd9;
        cyc();
        load = 1'b0; ctrl = 1'b1; en = 1'b1;
        ticks = 0;
        wraps = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            chk("sat_hold", 32'(b_count), 32'd9);
            ticks += int'(b_tick);
            wraps += int'(b_wrap);
        end
        $display("seq sat: ticks=%0d wraps=%0d", ticks, wraps);
        chk("sat_ticks", 32'(ticks), 32'd3);
        chk("sat_wraps", 32'(wraps), 32'd3);
        chk("wrapmode_after_12", 32'(a_count), 32'd2);
        ctrl = 1'b0;
        repeat (4) cyc();
        $display("seq sat: down count=%0d", b_count);
        chk("sat_down_count", 32'(b_count), 32'd8);
        chk("sat_down_wrap",  32'(b_wrap),  32'd0);
        chk("sat_down_tick",  32'(b_tick),  32'd1);

        // Pause keeps prescaler phase.
        load = 1'b1; load_val = 4'd0; ctrl = 1'b1; en = 1'b1;
        cyc();
        load = 1'b0;
        cyc(); cyc();
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("pause_tick", 32'(a_tick), 32'd0);
        end
        chk("pause_count", 32'(a_count), 32'd0);
        en = 1'b1;
        cyc();
        chk("resume1_tick", 32'(a_tick), 32'd0);
        cyc();
        $display("seq pause: resume count=%0d tick=%0d", a_count, a_tick);
        chk("resume2_tick",  32'(a_tick),  32'd1);
        chk("resume2_count", 32'(a_count), 32'd1);

        // Load clamps to MAX_VAL.
        en = 1'b0; load = 1'b1; load_val = 4'd13;
        cyc();
        $display("seq load13: count=%0d", a_count);
        chk("clamp_count", 32'(a_count), 32'd9);
        chk("clamp_at_max", 32'(a_max), 32'd1);

        // Load beats a coincident step and restarts the phase.
        load_val = 4'd0; en = 1'b1; ctrl = 1'b1;
        cyc();
        load = 1'b0;
        repeat (3) cyc();
        load = 1'b1; load_val = 4'd3;
        cyc();
        $display("seq load_vs_step: count=%0d tick=%0d", a_count, a_tick);
        chk("lvs_count", 32'(a_count), 32'd3);
        chk("lvs_tick",  32'(a_tick),  32'd0);
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("lvs_wait_tick", 32'(a_tick), 32'd0);
        end
        cyc();
        chk("lvs_next_count", 32'(a_count), 32'd4);
        chk("lvs_next_tick",  32'(a_tick),  32'd1);

        // Reset wins over load.
        rst = 1'b1; load = 1'b1; load_val = 4'd5;
        cyc();
        $display("seq rst+load: count=%0d", a_count);
        chk("rstload_count", 32'(a_count), 32'd0);
        chk("rstload_min",   32'(a_min),   32'd1);
        load = 1'b0;

        // TICK_DIV=1, 8-bit: step every enabled cycle, 255 -> 0 wraps.
        rst = 1'b1;
        cyc();
        rst = 1'b0; en = 1'b1; ctrl = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            cyc();
            chk("fast_count", 32'(c_count), 32'(k % 256));
            chk("fast_tick",  32'(c_tick),  32'd1);
            chk("fast_wrap",  32'(c_wrap),  32'(k == 256));
        end
        $display("seq fast: after 256 count=%0d wrap=%0d", c_count, c_wrap);
        repeat (5) cyc();
        chk("fast_mid_count", 32'(c_count), 32'd5);
        rst = 1'b1;
        cyc();
        $display("seq fast: mid-run reset count=%0d", c_count);
        chk("fast_rst_count", 32'(c_count), 32'd0);
        chk("fast_rst_tick",  32'(c_tick),  32'd0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/updown_counter_gen.md
Name: updown_counter_gen

Overview:
Parametrised up/down counter with an integrated tick prescaler. All logic runs on the single system clock; the prescaler produces a count-step strobe and never generates a derived clock. The block adds enable, synchronous load, programmable modulus, and wrap/saturate mode. It is the general counting primitive for board-level demo and timer logic, such as LED/7-seg counters and event timers.

Parameters:
WIDTH, 4, counter width in bits (1..32)
TICK_DIV, 100000000, clk cycles per count step (>=1; 1 = step every enabled cycle)
MAX_VAL, 2**WIDTH-1, terminal value; count range is 0..MAX_VAL (must be <= 2**WIDTH-1)
SATURATE, 0, 0 = wrap at boundaries, 1 = hold at boundaries

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  1 = prescaler runs and steps are allowed; 0 = pause
ctrl  input  1  direction: 1 = up, 0 = down
load  input  1  synchronous load strobe
load_val  input  WIDTH  value to load
count  output  WIDTH  current count, registered
tick  output  1  registered 1-cycle pulse, high in the cycle after each count step
wrap  output  1  registered 1-cycle pulse on a boundary event (see below)
at_max  output  1  combinational, count == MAX_VAL
at_min  output  1  combinational, count == 0

Behaviour:
- Priority per rising edge: rst > load > step > hold.
- Reset: count=0, prescaler=0, tick=0, wrap=0. Reset is synchronous and takes effect on the next edge, including mid-count.
- Prescaler:
  - Internal counter of width clog2(TICK_DIV) (min 1), range 0..TICK_DIV-1.
  - Increments only when en=1. When en=0 it holds its value, so a pause resumes without losing phase.
  - step = en && (prescaler == TICK_DIV-1). On step the prescaler returns to 0.
  - With TICK_DIV=1, step = en.
- Step, up (ctrl=1):
  - count < MAX_VAL: count+1.
  - count == MAX_VAL: wrap mode goes to 0 with wrap=1; saturate mode holds MAX_VAL with wrap=1.
- Step, down (ctrl=0):
  - count > 0: count-1.
  - count == 0: wrap mode goes to MAX_VAL with wrap=1; saturate mode holds 0 with wrap=1.
- ctrl is sampled only on the step edge. Changing it between steps has no effect until the next step.
- tick: 1 in the cycle following every step edge, including saturated steps where count does not change. Otherwise 0.
- wrap: 1 for exactly one cycle, aligned with tick, when the step hit a boundary as described above. Otherwise 0.
- Load:
  - load=1: count = min(load_val, MAX_VAL), prescaler=0, tick=0, wrap=0.
  - Load wins over a coincident step; that step is discarded.
  - Load works regardless of en.
- Out-of-range states cannot occur: count is always within 0..MAX_VAL.
- at_max and at_min are valid in every cycle, including during reset. After reset at_min=1.
- Arithmetic is done in WIDTH bits. Modulus logic compares against MAX_VAL explicitly and never relies on natural 2**WIDTH overflow, so a non-power-of-two MAX_VAL works.
- Latency: a step becomes visible on count at the same edge that ends prescaler period TICK_DIV. First step after reset/load comes TICK_DIV enabled cycles later.

Test Plan:
- Config WIDTH=4, TICK_DIV=4, MAX_VAL=9, SATURATE=0 unless noted; compare against a cycle-accurate reference model.
- Reset, then en=1, ctrl=1 for 44 cycles -> count steps every 4 cycles 0,1,..,9,0,1; tick pulses 11 times; wrap pulses once, on the 9->0 step.
- Count up to 0, then set ctrl=0 -> next step gives 9 with wrap=1, the following step gives 8 with wrap=0.
- SATURATE=1: load 9, up for 12 cycles -> count stays 9, tick pulses 3 times, wrap pulses 3 times. Then ctrl=0 -> 8.
- Pause: en=1 for 2 cycles, en=0 for 10 cycles, en=1 -> the first step occurs exactly 2 enabled cycles after resume, i.e. no phase loss.
- Load edge cases:
  - load_val=13 -> count=9 (clamped).
  - load on the same cycle as a step, load_val=3 -> count=3, tick=0, next step comes 4 cycles later.
  - rst with load -> count=0.
- TICK_DIV=1, WIDTH=8, MAX_VAL=255: en=1, ctrl=1 for 256 cycles -> count increments every cycle, 255->0 with wrap=1. Assert rst mid-run -> count=0 on the following edge.
